hps_input_sequencer: RTL and testbench

HPS_INPUT_SEQUENCER -- requirements
Module: hps_input_sequencer

---
 rtl/hps_input_sequencer.sv | 173 +++++++++++++++++
 tb/tb_hps_input_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_input_sequencer.sv
// Register-programmed FIFO that streams frames of LEN words on a valid/ready port.
// Optional interrupt output enabled by defining HPS_INPUT_SEQ_IRQ_EN.
module hps_input_sequencer #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef HPS_INPUT_SEQ_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [7:0]        len_q;
    logic [7:0]        frame_len_q;
    logic [7:0]        sent_q;
    logic [DATA_W-1:0] last_word_q;
    logic              done_q;
    logic              ovf_q;
    logic              irq_en_q;

    logic wr;
    logic data_wr;
    logic ctrl_wr;
    logic stat_wr;
    logic len_wr;
    logic flush;
    logic start;
    logic push_req;
    logic push_ok;
    logic pop;
    logic empty;
    logic full;
    logic run;
    logic unused_wd;

    assign wr      = chipselect && !write_n;
    assign data_wr = wr && (address == 2'd0);
    assign ctrl_wr = wr && (address == 2'd1);
    assign stat_wr = wr && (address == 2'd2);
    assign len_wr  = wr && (address == 2'd3);

    // Flush dominates every other same-cycle action.
    assign flush    = ctrl_wr && writedata[1];
    assign start    = ctrl_wr && writedata[0] && !flush && (state_q == IDLE) && (len_q != 8'd0);
    assign push_req = data_wr && !flush;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign run       = (state_q == RUN);
    assign out_valid = run && !empty;
    assign out_last  = out_valid && (sent_q == (frame_len_q - 8'd1));
    assign out_data  = empty ? '0 : mem[rd_ptr_q];

    assign pop     = out_valid && out_ready && !flush;
    assign push_ok = push_req && (!full || pop);

    assign unused_wd = ^writedata;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (pop && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FIFO storage has no reset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= writedata[DATA_W-1:0];
    end

    // FIFO pointers, fill count and frame progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sent_q      <= 8'd0;
            frame_len_q <= 8'd0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sent_q   <= 8'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                sent_q   <= sent_q + 8'd1;
            end
            if (push_ok && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push_ok) count_q <= count_q - CW'(1);
            // LEN is sampled only here so mid-frame LEN writes wait for the next frame.
            if (start) begin
                sent_q      <= 8'd0;
                frame_len_q <= len_q;
            end
        end
    end

    // Software-visible registers and sticky status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q       <= 8'd0;
            last_word_q <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (len_wr)  len_q       <= writedata[7:0];
            if (data_wr) last_word_q <= writedata[DATA_W-1:0];

            if (pop && out_last)                done_q <= 1'b1;
            else if (stat_wr && writedata[10])  done_q <= 1'b0;

            if (push_req && full && !pop)       ovf_q <= 1'b1;
            else if (stat_wr && writedata[11])  ovf_q <= 1'b0;
        end
    end

`ifdef HPS_INPUT_SEQ_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     irq_en_q <= 1'b0;
        else if (ctrl_wr) irq_en_q <= writedata[2];
    end

    assign irq = done_q && irq_en_q;
`else
    assign irq_en_q = 1'b0;
`endif

    // Register read mux
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(last_word_q);
            2'd1:    readdata = {29'd0, irq_en_q, 1'b0, run};
            2'd2:    readdata = {20'd0, ovf_q, done_q, full, empty, 1'b0, 7'(count_q)};
            default: readdata = {24'd0, len_q};
        endcase
    end

endmodule

// File: tb/tb_hps_input_sequencer.sv
// Directed self-checking bench for hps_input_sequencer (DATA_W=20, DEPTH=16).
module tb_hps_input_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
`ifdef HPS_INPUT_SEQ_IRQ_EN
    logic        irq;
    localparam logic [31:0] CTRL_IRQ_RD = 32'h4;
`else
    localparam logic [31:0] CTRL_IRQ_RD = 32'h0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    hps_input_sequencer #(.DATA_W(20), .DEPTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
`ifdef HPS_INPUT_SEQ_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", out_last); end
        n_tests++; if (out_data !== 20'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data); end
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h100) begin n_fail++; $display("FAIL reset_status got %h exp 00000100", rd); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        read_reg(2'd1, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h exp 0", rd); end
        read_reg(2'd3, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_len got %h exp 0", rd); end
        read_reg(2'd0, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_lastword got %h exp 0", rd); end
    endtask

    task automatic test_start_ignored();
        logic [31:0] rd;
        bus_write(2'd1, 32'h1);
        read_reg(2'd1, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL start_len0 ctrl got %h exp 0", rd); end
        bus_write(2'd1, 32'h4);
        read_reg(2'd1, rd);
        n_tests++; if (rd !== CTRL_IRQ_RD) begin n_fail++; $display("FAIL irq_en_read got %h exp %h", rd, CTRL_IRQ_RD); end
        bus_write(2'd1, 32'h0);
    endtask

    task automatic test_frame();
        logic [31:0] rd;
        bus_write(2'd3, 32'd3);
        bus_write(2'd0, 32'h00001);
        bus_write(2'd0, 32'h00002);
        bus_write(2'd0, 32'h00003);
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h3) begin n_fail++; $display("FAIL frame_fill got %h exp 00000003", rd); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL frame_idle_valid got %b exp 0", out_valid); end
        bus_write(2'd1, 32'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (out_valid !== 1'b1 || out_data !== 20'(i + 1) || out_last !== (i == 2))
                begin n_fail++; $display("FAIL frame_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, out_valid, out_data, out_last, 20'(i + 1), (i == 2)); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL frame_end_valid got %b exp 0", out_valid); end
        read_reg(2'd1, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL frame_end_run got %h exp 0", rd); end
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h500) begin n_fail++; $display("FAIL frame_done got %h exp 00000500", rd); end
        read_reg(2'd0, rd);
        n_tests++; if (rd !== 32'h3) begin n_fail++; $display("FAIL frame_lastword got %h exp 00000003", rd); end
        bus_write(2'd2, 32'h400);
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h100) begin n_fail++; $display("FAIL done_clear got %h exp 00000100", rd); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        for (int i = 0; i < 17; i++) bus_write(2'd0, 32'h100 + 32'(i));
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'hA10) begin n_fail++; $display("FAIL ovf_status got %h exp 00000a10", rd); end
        bus_write(2'd2, 32'h800);
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h210) begin n_fail++; $display("FAIL ovf_clear got %h exp 00000210", rd); end
        bus_write(2'd3, 32'd16);
        bus_write(2'd1, 32'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (out_valid !== 1'b1 || out_data !== 20'(32'h100 + 32'(i)) || out_last !== (i == 15))
                begin n_fail++; $display("FAIL ovf_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, out_valid, out_data, out_last, 20'(32'h100 + 32'(i)), (i == 15)); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_no17th got v=%b d=%h exp v=0", out_valid, out_data); end
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h500) begin n_fail++; $display("FAIL ovf_done got %h exp 00000500", rd); end
        bus_write(2'd2, 32'h400);
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        bus_write(2'd3, 32'd4);
        for (int i = 0; i < 4; i++) bus_write(2'd0, 32'h11 + 32'(i));
        bus_write(2'd1, 32'h1);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++; if (out_data !== 20'h13) begin n_fail++; $display("FAIL flush_pre got %h exp 00013", out_data); end
        bus_write(2'd1, 32'h2);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h100) begin n_fail++; $display("FAIL flush_status got %h exp 00000100", rd); end
        read_reg(2'd1, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL flush_run got %h exp 0", rd); end
        for (int i = 0; i < 4; i++) bus_write(2'd0, 32'h21 + 32'(i));
        bus_write(2'd1, 32'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (out_valid !== 1'b1 || out_data !== 20'(32'h21 + 32'(i)) || out_last !== (i == 3))
                begin n_fail++; $display("FAIL restart_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, out_valid, out_data, out_last, 20'(32'h21 + 32'(i)), (i == 3)); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h500) begin n_fail++; $display("FAIL restart_done got %h exp 00000500", rd); end
        bus_write(2'd2, 32'h400);
    endtask

    task automatic test_stall();
        logic [31:0] rd;
        bus_write(2'd3, 32'd2);
        bus_write(2'd1, 32'h1);
        read_reg(2'd1, rd);
        n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL stall_run got %h exp 00000001", rd); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty_valid got %b exp 0", out_valid); end
        bus_write(2'd3, 32'd1);
        bus_write(2'd0, 32'hABCDE);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 20'hABCDE || out_last !== 1'b0)
            begin n_fail++; $display("FAIL stall_fwft got v=%b d=%h l=%b exp v=1 d=abcde l=0", out_valid, out_data, out_last); end
        repeat (3) @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 20'hABCDE)
            begin n_fail++; $display("FAIL stall_hold got v=%b d=%h exp v=1 d=abcde", out_valid, out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_accepted got %b exp 0", out_valid); end
        bus_write(2'd0, 32'h12345);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 20'h12345 || out_last !== 1'b1)
            begin n_fail++; $display("FAIL stall_second got v=%b d=%h l=%b exp v=1 d=12345 l=1", out_valid, out_data, out_last); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h500) begin n_fail++; $display("FAIL stall_done got %h exp 00000500", rd); end
        read_reg(2'd3, rd);
        n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL stall_len got %h exp 00000001", rd); end
        bus_write(2'd2, 32'h400);
    endtask

    task automatic test_full_pushpop();
        logic [31:0] rd;
        bus_write(2'd3, 32'd20);
        bus_write(2'd1, 32'h1);
        for (int i = 0; i < 16; i++) bus_write(2'd0, 32'h30 + 32'(i));
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h210) begin n_fail++; $display("FAIL full_status got %h exp 00000210", rd); end
        @(negedge clk);
        address = 2'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h40; out_ready = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0; out_ready = 1'b0;
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h210) begin n_fail++; $display("FAIL pushpop_status got %h exp 00000210", rd); end
        n_tests++; if (out_data !== 20'h31) begin n_fail++; $display("FAIL pushpop_head got %h exp 00031", out_data); end
        bus_write(2'd1, 32'h2);
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h100) begin n_fail++; $display("FAIL full_flush got %h exp 00000100", rd); end
    endtask

    task automatic test_reset_run();
        logic [31:0] rd;
        bus_write(2'd3, 32'd2);
        bus_write(2'd0, 32'h55);
        bus_write(2'd1, 32'h1);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstrun_pre got %b exp 1", out_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || out_data !== 20'h0)
            begin n_fail++; $display("FAIL rstrun_async got v=%b d=%h exp v=0 d=0", out_valid, out_data); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        read_reg(2'd2, rd);
        n_tests++; if (rd !== 32'h100) begin n_fail++; $display("FAIL rstrun_status got %h exp 00000100", rd); end
        read_reg(2'd1, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstrun_ctrl got %h exp 0", rd); end
    endtask

`ifdef HPS_INPUT_SEQ_IRQ_EN
    task automatic test_irq();
        bus_write(2'd1, 32'h4);
        bus_write(2'd3, 32'd1);
        bus_write(2'd0, 32'h7);
        bus_write(2'd1, 32'h5);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_pre got %b exp 0", irq); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b exp 1", irq); end
        bus_write(2'd2, 32'h400);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b exp 0", irq); end
    endtask
`endif

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        out_ready  = 1'b0;
        test_reset();
        test_start_ignored();
        test_frame();
        test_overflow();
        test_flush();
        test_stall();
        test_full_pushpop();
        test_reset_run();
`ifdef HPS_INPUT_SEQ_IRQ_EN
        test_irq();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
